ram2x4_ctrl: RTL and testbench

Access controller that drives a 2-word × 4-bit RAM (clear / readWrite / address / data-in / data-out port set) on behalf of an upstream requester. It accepts single read, single write, memory-clear and built-in self-test commands over a req/busy/done handshake, sequences the RAM control pins cycle by cycle, and returns read data and a pass/fail flag. It sits between test or processor logic and the RAM, and is the initiating end of that RAM's port.

---
 rtl/ram2x4_ctrl.sv | 129 ++++++++++++
 tb/tb_ram2x4_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ram2x4_ctrl.sv
// ram2x4_ctrl -- access controller for a 2-word RAM with a
// clear / readWrite / address / data-in / data-out port set.
//
// Accepts read, write, clear-memory and self-test commands over a
// req/busy/done handshake and sequences the RAM pins one state per cycle.
//
// Ports:
//   clk, clear          clock, synchronous active-high reset
//   req, op, addr, wdata command request (op: 00 rd, 01 wr, 10 test, 11 clr)
//   busy, done          handshake status (done is a one-cycle pulse)
//   rdata, err          last read word, self-test mismatch flag
//   mem_d, mem_rw,
//   mem_addr, mem_clr   RAM drive pins (mem_rw=1 writes at the next edge)
//   mem_q               RAM data-out, combinational for mem_addr
//
// Every output is a register loaded from the state being entered, so the
// mem_* pins hold their value for the whole cycle spent in a state.
module ram2x4_ctrl #(
  parameter int                DATA_W  = 4,
  parameter logic [DATA_W-1:0] PATTERN = 4'b1100
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              req,
  input  logic [1:0]        op,
  input  logic              addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_rw,
  output logic              mem_addr,
  output logic              mem_clr,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR, S_RD, S_CLR, S_TW0, S_TW1, S_TR0, S_TR1, S_DONE
  } state_t;

  state_t state, state_n;

  logic              busy_n, done_n, mem_rw_n, mem_addr_n, mem_clr_n;
  logic [DATA_W-1:0] mem_d_n;

  always_ff @(posedge clk) begin
    if (clear) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (req) begin
        case (op)
          2'b00:   state_n = S_RD;
          2'b01:   state_n = S_WR;
          2'b10:   state_n = S_TW0;
          default: state_n = S_CLR;
        endcase
      end
      S_WR, S_RD, S_CLR, S_TR1: state_n = S_DONE;
      S_TW0:                    state_n = S_TW1;
      S_TW1:                    state_n = S_TR0;
      S_TR0:                    state_n = S_TR1;
      default:                  state_n = S_IDLE;
    endcase
  end

  // Output values for the state being entered. WR and RD are only ever
  // entered from IDLE on the accepting edge, so the live addr/wdata are the
  // request's values; the output registers themselves hold them afterwards.
  always_comb begin
    busy_n     = (state_n != S_IDLE);
    done_n     = (state_n == S_DONE);
    mem_rw_n   = 1'b0;
    mem_clr_n  = 1'b0;
    mem_addr_n = 1'b0;
    mem_d_n    = '0;
    case (state_n)
      S_WR:  begin mem_rw_n = 1'b1; mem_addr_n = addr; mem_d_n = wdata; end
      S_RD:  mem_addr_n = addr;
      S_CLR: mem_clr_n = 1'b1;
      S_TW0: begin mem_rw_n = 1'b1; mem_addr_n = 1'b0; mem_d_n = PATTERN; end
      S_TW1: begin mem_rw_n = 1'b1; mem_addr_n = 1'b1; mem_d_n = ~PATTERN; end
      S_TR0: mem_addr_n = 1'b0;
      S_TR1: mem_addr_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_rw   <= 1'b0;
      mem_clr  <= 1'b0;
      mem_addr <= 1'b0;
      mem_d    <= '0;
    end else begin
      busy     <= busy_n;
      done     <= done_n;
      mem_rw   <= mem_rw_n;
      mem_clr  <= mem_clr_n;
      mem_addr <= mem_addr_n;
      mem_d    <= mem_d_n;
    end
  end

  // Read data is taken from mem_q at the end of each read-state cycle.
  // err is cleared on acceptance and then only ever set during TR0/TR1.
  always_ff @(posedge clk) begin
    if (clear) begin
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      if (state == S_IDLE && req) err <= 1'b0;
      if (state == S_RD) rdata <= mem_q;
      if (state == S_TR0 && mem_q != PATTERN) err <= 1'b1;
      if (state == S_TR1) begin
        rdata <= mem_q;
        if (mem_q != ~PATTERN) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram2x4_ctrl.sv
// Bench for ram2x4_ctrl: behavioural RAM with optional stuck-at-1 bits on
// its data-out, plus a command-level reference model of memory contents,
// read data and the self-test flag.
module tb_ram2x4_ctrl;
  localparam logic [3:0] P = 4'b1100;

  logic       clk = 1'b0;
  logic       clear, req, addr;
  logic [1:0] op;
  logic [3:0] wdata, rdata, mem_d, mem_q;
  logic       busy, done, err, mem_rw, mem_addr, mem_clr;

  ram2x4_ctrl dut (
    .clk(clk), .clear(clear), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .err(err), .mem_d(mem_d),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_clr(mem_clr), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // RAM: write/clear at the rising edge, combinational read.
  logic [3:0] ram [2] = '{4'd0, 4'd0};
  logic [3:0] stuck = 4'd0;
  assign mem_q = ram[mem_addr] | stuck;
  always @(posedge clk) begin
    if (mem_clr)     begin ram[0] <= 4'd0; ram[1] <= 4'd0; end
    else if (mem_rw) ram[mem_addr] <= mem_d;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pin activity log, sampled mid-cycle.
  logic [4:0] wr_log[$];
  int         clr_cnt = 0;
  always @(negedge clk) begin
    chk("rw_clr_exclusive", 32'(mem_rw & mem_clr), 32'd0);
    if (mem_rw)  wr_log.push_back({mem_addr, mem_d});
    if (mem_clr) clr_cnt++;
  end

  // Reference model state.
  logic [3:0] mref [2] = '{4'd0, 4'd0};
  logic [3:0] rd_exp = 4'd0;
  logic       err_exp = 1'b0;

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mem_d", 32'(mem_d), 32'd0);
    chk("rst_mem_rw", 32'(mem_rw), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_clr", 32'(mem_clr), 32'd0);
  endtask

  // Issue one command from IDLE and check the whole transaction.
  task automatic run_cmd(input logic [1:0] o, input logic a, input logic [3:0] wd);
    int         n, exp_n, exp_clr;
    logic [4:0] exp_w[$];
    exp_n = 1; exp_clr = 0; err_exp = 1'b0;
    case (o)
      2'b01: begin mref[a] = wd; exp_w.push_back({a, wd}); end
      2'b00: rd_exp = mref[a] | stuck;
      2'b11: begin mref[0] = 4'd0; mref[1] = 4'd0; exp_clr = 1; end
      default: begin
        mref[0] = P; mref[1] = ~P;
        exp_w.push_back({1'b0, P}); exp_w.push_back({1'b1, ~P});
        rd_exp  = mref[1] | stuck;
        err_exp = ((mref[0] | stuck) != P) || (rd_exp != ~P);
        exp_n   = 4;
      end
    endcase
    wr_log.delete(); clr_cnt = 0;
    req = 1'b1; op = o; addr = a; wdata = wd;
    step;
    // Scramble the request inputs: the command must use latched values.
    req = 1'b0; op = 2'($urandom); addr = 1'($urandom); wdata = 4'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 20) begin step; n++; end
    chk("done_latency", 32'(n), 32'(exp_n));
    chk("busy_at_done", 32'(busy), 32'd1);
    chk("rdata", 32'(rdata), 32'(rd_exp));
    chk("err", 32'(err), 32'(err_exp));
    chk("write_count", 32'(wr_log.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < wr_log.size(); i++)
      chk("write_addr_data", 32'(wr_log[i]), 32'(exp_w[i]));
    chk("clear_cycles", 32'(clr_cnt), 32'(exp_clr));
    step;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_low_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    clear = 1'b1; req = 1'b0; op = 2'b00; addr = 1'b0; wdata = 4'd0;
    step; step;
    chk_reset_outputs();
    clear = 1'b0;
    step;

    // Round trip, clear, self-test pass.
    run_cmd(2'b01, 1'b0, 4'b1100);
    run_cmd(2'b01, 1'b1, 4'b0011);
    run_cmd(2'b00, 1'b0, 4'd0);
    run_cmd(2'b00, 1'b1, 4'd0);
    run_cmd(2'b11, 1'b0, 4'd0);
    run_cmd(2'b00, 1'b1, 4'd0);
    run_cmd(2'b10, 1'b0, 4'd0);

    // Write request raised during a read: ignored until the IDLE edge.
    req = 1'b1; op = 2'b00; addr = 1'b0;
    rd_exp = mref[0];
    step;                                   // RD
    op = 2'b01; addr = 1'b1; wdata = 4'b1010;
    chk("busy_rd_norw", 32'(mem_rw), 32'd0);
    step;                                   // DONE
    chk("busy_done_norw", 32'(mem_rw), 32'd0);
    chk("busy_done_pulse", 32'(done), 32'd1);
    chk("busy_rd_data", 32'(rdata), 32'(rd_exp));
    step;                                   // IDLE
    chk("busy_idle_norw", 32'(mem_rw), 32'd0);
    chk("busy_idle_low", 32'(busy), 32'd0);
    step;                                   // WR
    req = 1'b0;
    chk("held_req_rw", 32'(mem_rw), 32'd1);
    chk("held_req_addr", 32'(mem_addr), 32'd1);
    chk("held_req_d", 32'(mem_d), 32'(4'b1010));
    mref[1] = 4'b1010;
    step; step;                             // DONE, IDLE
    chk("held_req_idle", 32'(busy), 32'd0);

    // Reset in the middle of a self-test (during TW1).
    req = 1'b1; op = 2'b10;
    step;                                   // TW0
    req = 1'b0;
    step;                                   // TW1
    chk("tw1_rw", 32'(mem_rw), 32'd1);
    chk("tw1_addr", 32'(mem_addr), 32'd1);
    clear = 1'b1;
    step; step;
    chk_reset_outputs();
    clear = 1'b0;
    // TW0 completed; TW1's write was still driven at the first reset edge.
    mref[0] = P; mref[1] = ~P; rd_exp = 4'd0; err_exp = 1'b0;
    step;
    chk("post_rst_rw", 32'(mem_rw), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    run_cmd(2'b00, 1'b1, 4'd0);

    // Self-test fail with data-out bit 0 stuck at 1.
    stuck = 4'b0001;
    run_cmd(2'b10, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("err_held_idle", 32'(err), 32'd1);
    end
    run_cmd(2'b00, 1'b0, 4'd0);
    stuck = 4'd0;

    // Random command stream.
    for (int i = 0; i < 40; i++)
      run_cmd(2'($urandom_range(0, 3)), 1'($urandom), 4'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
